// File: rtl/operand_issue_ctrl.sv
// Execute-stage operand B sequencer: captures one decoded op per handshake,
// holds operand B for a fixed number of execute cycles or pulses a PC load.
module operand_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int IMM_W       = 17,
    parameter int PCOFF_W     = 12,
    parameter int EXEC_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_regB,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic               in_imme_en,
    input  logic               in_branch,
    input  logic               stall,
    input  logic               flush,
    output logic [DATA_W-1:0]  alu_opB,
    output logic               alu_valid,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               pc_load,
    output logic [PCOFF_W-1:0] pc_offset,
    output logic               busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] BRANCH = 2'd2;

    localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        counter;
    logic [DATA_W-1:0] imm_sext;
    logic              accept;

    assign imm_sext  = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    assign in_ready  = (state == IDLE) & ~flush;
    assign accept    = in_valid & in_ready;

    // Handshake flags decode straight from the state register.
    assign alu_valid = (state == EXEC);
    assign pc_load   = (state == BRANCH);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            alu_opB    <= '0;
            dmem_wdata <= '0;
            pc_offset  <= '0;
        end else if (flush) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (accept) begin
                        if (in_branch) begin
                            pc_offset <= in_imm[PCOFF_W-1:0];
                            state     <= BRANCH;
                        end else begin
                            alu_opB    <= in_imme_en ? imm_sext : in_regB;
                            dmem_wdata <= in_regB;
                            counter    <= '0;
                            state      <= EXEC;
                        end
                    end
                end
                (state == EXEC): begin
                    if (!stall) begin
                        counter <= counter + 4'd1;
                        if (counter == LAST) begin
                            state <= IDLE;
                        end
                    end
                end
                (state == BRANCH): begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/operand_issue_ctrl.md
Name: operand_issue_ctrl

Overview:
Sequencing controller for the execute-stage operand path. It accepts one decoded instruction per handshake and selects ALU operand B: either the register-B value or the fully sign-extended 17-bit immediate. It holds that operand stable for a fixed number of execute cycles, or issues a one-cycle PC-relative load for branches. It sits between decode and the ALU / PC / data-memory write port, and replaces the combinational operand-B steering.

Parameters:
DATA_W, 32, datapath width
IMM_W, 17, immediate field width
PCOFF_W, 12, PC offset width (low bits of immediate)
EXEC_CYCLES, 2, cycles alu_valid is asserted per non-branch op (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  controller can accept (high only in IDLE and flush low)
in_regB  input  DATA_W  register-file read port B data
in_imm  input  IMM_W  immediate field
in_imme_en  input  1  1 = operand B is immediate, 0 = register B
in_branch  input  1  1 = branch, use in_imm[PCOFF_W-1:0] as PC offset
stall  input  1  freezes EXEC cycle counter
flush  input  1  abort current op, return to IDLE
alu_opB  output  DATA_W  registered operand B
alu_valid  output  1  operand B valid for ALU
dmem_wdata  output  DATA_W  registered in_regB (store data)
pc_load  output  1  one-cycle branch load pulse
pc_offset  output  PCOFF_W  registered branch offset
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, BRANCH. All registers update on the rising edge of clk.
- rst (synchronous, active-high) has the highest priority. It forces state=IDLE, counter=0, alu_opB=0, dmem_wdata=0, pc_offset=0, alu_valid=0, pc_load=0, busy=0.
- rst mid-operation discards the op; no further pc_load or alu_valid is produced.
- in_ready = (state==IDLE) & ~flush. Combinational; no dependence on in_valid.
- Accept = in_valid & in_ready at an edge. All data inputs are captured on that edge only.
- On accept with in_branch=1:
  - pc_offset <= in_imm[PCOFF_W-1:0]; alu_opB and dmem_wdata keep their previous values.
  - Next state BRANCH.
- On accept with in_branch=0:
  - alu_opB <= in_imme_en ? sign-extended in_imm : in_regB. Sign extension replicates in_imm[IMM_W-1] into bits DATA_W-1..IMM_W.
  - dmem_wdata <= in_regB; counter <= 0.
  - Next state EXEC.
- BRANCH: lasts exactly one cycle; pc_load=1 during it (registered, decoded from state), then IDLE. stall is ignored in BRANCH.
- EXEC: alu_valid=1 for every cycle in EXEC.
  - If ~stall: counter increments.
  - When counter==EXEC_CYCLES-1 and ~stall: next state IDLE.
  - If stall: counter and state hold, so alu_valid is extended.
- Latency: accept at edge k.
  - Non-branch: alu_valid high in cycles k+1..k+EXEC_CYCLES (no stall); in_ready high again in cycle k+EXEC_CYCLES+1.
  - Branch: pc_load high in cycle k+1 only; in_ready high in cycle k+2.
- flush takes priority over stall and accept. In any state, next state=IDLE and counter=0.
  - Flush in BRANCH does not cancel that cycle's pc_load, which is already asserted.
  - Flush in IDLE blocks accept via in_ready.
  - Data registers are not cleared by flush.
- alu_opB, dmem_wdata and pc_offset hold their last captured values in IDLE.
- alu_valid and pc_load are never high simultaneously.

Test Plan:
1. Reset then idle: after rst, check all outputs = 0 and in_ready=1. Then assert in_valid with rst=1 -> no accept, busy=0.
2. Immediate negative: in_imm=17'h1FFFF, imme_en=1, regB=32'h12345678 -> alu_opB=32'hFFFFFFFF and dmem_wdata=32'h12345678. alu_valid is high for exactly 2 cycles; in_ready returns on the 3rd cycle after accept.
3. Immediate positive vs register: in_imm=17'h0ABCD, imme_en=1 -> alu_opB=32'h0000ABCD. Next op with imme_en=0, regB=32'hDEADBEEF -> alu_opB=32'hDEADBEEF.
4. Branch: in_branch=1, in_imm=17'h00F3C -> pc_offset=12'hF3C and pc_load high for exactly one cycle. alu_valid stays 0 and alu_opB is unchanged.
5. Stall: non-branch op with stall=1 for 3 cycles starting in the first EXEC cycle -> alu_valid high for 5 cycles total; operands stable throughout.
6. Flush: assert flush in the first EXEC cycle -> alu_valid low next cycle and state IDLE. Assert flush with in_valid=1 in IDLE -> in_ready=0 and no capture.
